telemetry_framer: RTL

Parametrised successor to the fixed-format logger. It snapshots NUM_FIELDS words of FIELD_WIDTH bits plus the IAGC status, frames them as sync, status, length, payload and checksum bytes, and streams them to uart_tx over the start_tx/ready handshake. It adds rate limiting, status-change priority frames and a dropped-update counter. It sits on clock0 between the amplitude/processor outputs and u_uart_tx.

---
 rtl/iagc_pkg.sv | 31 +++
 rtl/tx_byte_handshake.sv | 64 ++++++
 rtl/telemetry_framer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/iagc_pkg.sv
// rtl/iagc_pkg.sv - shared IAGC status encodings, framer states and frame helpers
//
// Purpose : common definitions for the telemetry framer and its byte handshake.
// Contents: IAGC_STATUS_SIZE, IAGC status encodings, framer_state_e,
//           DEFAULT_SYNC_BYTE, frame_len() payload-length helper.
package iagc_pkg;

    localparam int IAGC_STATUS_SIZE = 4;

    // Global IAGC FSM status encodings as seen on i_iagcStatus.
    localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_ST_IDLE    = 4'h0;
    localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_ST_ACQUIRE = 4'h1;
    localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_ST_TRACK   = 4'h3;
    localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_ST_HOLD    = 4'h5;
    localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_ST_FAULT   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_RDY
    } framer_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Payload length in bytes (the LEN byte of a frame).
    function automatic int frame_len(input int num_fields, input int field_width);
        return (num_fields * field_width) / 8;
    endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// rtl/tx_byte_handshake.sv - one-byte strobe-and-wait handshake toward uart_tx
//
// Purpose : walks SEND -> WAIT_ACK -> WAIT_RDY for each byte of a frame.
// Ports   : i_clock, i_nReset (async active-low)
//           i_start     capture pulse, leaves IDLE for SEND
//           i_last      current byte is the final byte of the frame
//           i_txReady   uart_tx ready
//           o_txValid   registered single-cycle start_tx strobe
//           o_byte_done byte fully handed over (WAIT_RDY saw ready)
module tx_byte_handshake (
    input  logic i_clock,
    input  logic i_nReset,
    input  logic i_start,
    input  logic i_last,
    input  logic i_txReady,
    output logic o_txValid,
    output logic o_byte_done
);
    import iagc_pkg::*;

    framer_state_e state_q, state_d;
    logic          tx_valid_q, tx_valid_d;

    always_comb begin
        state_d     = state_q;
        tx_valid_d  = 1'b0;
        o_byte_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (i_txReady) begin
                    tx_valid_d = 1'b1;
                    state_d    = ST_WAIT_ACK;
                end
            end
            // uart_tx acknowledges the strobe by dropping ready.
            ST_WAIT_ACK: begin
                if (!i_txReady) state_d = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (i_txReady) begin
                    o_byte_done = 1'b1;
                    state_d     = i_last ? ST_IDLE : ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign o_txValid = tx_valid_q;

endmodule

// File: rtl/telemetry_framer.sv
// rtl/telemetry_framer.sv - rate-limited telemetry framer feeding uart_tx
//
// Purpose : snapshots NUM_FIELDS payload words plus IAGC status and streams
//           SYNC, STATUS, LEN, payload (field 0 first, MSB byte first), CHK.
// Ports   : i_clock, i_nReset (async active-low)
//           i_iagcStatus  IAGC status, i_fields payload (field 0 in LSBs)
//           i_update      new-fields strobe, i_enable framing allowed
//           i_txReady     uart_tx ready
//           o_txData/o_txValid byte and start_tx strobe toward uart_tx
//           o_busy        capture until last byte accepted
//           o_dropCount   saturating count of rejected updates
module telemetry_framer #(
    parameter int         IAGC_STATUS_SIZE = iagc_pkg::IAGC_STATUS_SIZE,
    parameter int         NUM_FIELDS       = 4,
    parameter int         FIELD_WIDTH      = 16,
    parameter int         UART_DATA_SIZE   = 8,
    parameter logic [7:0] SYNC_BYTE        = iagc_pkg::DEFAULT_SYNC_BYTE,
    parameter int         MIN_GAP_CYCLES   = 1_000_000,
    parameter int         DROP_COUNT_SIZE  = 16
) (
    input  logic                                i_clock,
    input  logic                                i_nReset,
    input  logic [IAGC_STATUS_SIZE-1:0]         i_iagcStatus,
    input  logic [NUM_FIELDS*FIELD_WIDTH-1:0]   i_fields,
    input  logic                                i_update,
    input  logic                                i_enable,
    input  logic                                i_txReady,
    output logic [UART_DATA_SIZE-1:0]           o_txData,
    output logic                                o_txValid,
    output logic                                o_busy,
    output logic [DROP_COUNT_SIZE-1:0]          o_dropCount
);
    import iagc_pkg::*;

    localparam int FRAME_LEN       = frame_len(NUM_FIELDS, FIELD_WIDTH);
    localparam int BYTES_PER_FIELD = FIELD_WIDTH / 8;
    localparam int LAST_IDX        = FRAME_LEN + 3;
    localparam int IDX_W           = $clog2(LAST_IDX + 1);
    localparam int GAP_W           = $clog2(MIN_GAP_CYCLES + 2);

    localparam logic [IDX_W-1:0]           IDX_SYNC   = '0;
    localparam logic [IDX_W-1:0]           IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0]           IDX_LEN    = IDX_W'(2);
    localparam logic [IDX_W-1:0]           IDX_CHK    = IDX_W'(LAST_IDX);
    localparam logic [GAP_W-1:0]           GAP_MAX    = GAP_W'(MIN_GAP_CYCLES);
    localparam logic [DROP_COUNT_SIZE-1:0] DROP_MAX   = '1;

    logic [NUM_FIELDS*FIELD_WIDTH-1:0] snap_fields_q, snap_fields_d;
    logic [IAGC_STATUS_SIZE-1:0]       snap_status_q, snap_status_d;
    logic [IAGC_STATUS_SIZE-1:0]       shadow_q, shadow_d;
    logic                              shadow_vld_q, shadow_vld_d;
    logic [GAP_W-1:0]                  gap_q, gap_d;
    logic                              busy_q, busy_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [UART_DATA_SIZE-1:0]         chk_q, chk_d;
    logic [UART_DATA_SIZE-1:0]         tx_data_q, tx_data_d;
    logic [DROP_COUNT_SIZE-1:0]        drop_q, drop_d;
    logic [UART_DATA_SIZE-1:0]         byte_sel;

    logic status_change, gap_open, capture, last_byte, byte_done, tx_valid;

    // The shadow is loaded from the live status on the first cycle after
    // reset, so no status-change frame is raised by reset release alone.
    assign status_change = shadow_vld_q && (i_iagcStatus != shadow_q);
    assign gap_open      = (gap_q >= GAP_MAX);
    assign capture       = !busy_q && i_enable && ((i_update && gap_open) || status_change);
    assign last_byte     = (idx_q == IDX_CHK);

    always_comb begin
        snap_fields_d = snap_fields_q;
        snap_status_d = snap_status_q;
        shadow_vld_d  = 1'b1;
        shadow_d      = shadow_q;
        gap_d         = gap_open ? GAP_MAX : gap_q + 1'b1;
        busy_d        = busy_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        drop_d        = drop_q;

        // While framing is disabled the shadow follows the bus, so a status
        // that changed during the disabled window does not trigger a frame.
        if (!shadow_vld_q || !i_enable) shadow_d = i_iagcStatus;

        if (i_update && i_enable && !capture && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 1'b1;
        end

        if (capture) begin
            snap_fields_d = i_fields;
            snap_status_d = i_iagcStatus;
            shadow_d      = i_iagcStatus;
            gap_d         = '0;
            busy_d        = 1'b1;
            idx_d         = IDX_SYNC;
            chk_d         = '0;
        end

        // tx_data_q holds the byte just handed over; SYNC and CHK are not summed.
        if (byte_done) begin
            if ((idx_q != IDX_SYNC) && !last_byte) chk_d = chk_q + tx_data_q;
            if (last_byte) begin
                busy_d = 1'b0;
                idx_d  = IDX_SYNC;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Byte for the next index, registered so o_txData only moves when the
    // index moves (capture or WAIT_RDY exit).
    always_comb begin
        byte_sel = '0;
        if (idx_d == IDX_SYNC) begin
            byte_sel = UART_DATA_SIZE'(SYNC_BYTE);
        end else if (idx_d == IDX_STATUS) begin
            byte_sel = UART_DATA_SIZE'(snap_status_d);
        end else if (idx_d == IDX_LEN) begin
            byte_sel = UART_DATA_SIZE'(FRAME_LEN);
        end else if (idx_d == IDX_CHK) begin
            byte_sel = chk_d;
        end else begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                if (idx_d == IDX_W'(k + 3)) begin
                    byte_sel = snap_fields_d[(k / BYTES_PER_FIELD) * FIELD_WIDTH
                                + (BYTES_PER_FIELD - 1 - (k % BYTES_PER_FIELD)) * 8
                                +: UART_DATA_SIZE];
                end
            end
        end
        tx_data_d = busy_d ? byte_sel : tx_data_q;
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            snap_fields_q <= '0;
            snap_status_q <= '0;
            shadow_q      <= '0;
            shadow_vld_q  <= 1'b0;
            gap_q         <= GAP_MAX;
            busy_q        <= 1'b0;
            idx_q         <= IDX_SYNC;
            chk_q         <= '0;
            tx_data_q     <= '0;
            drop_q        <= '0;
        end else begin
            snap_fields_q <= snap_fields_d;
            snap_status_q <= snap_status_d;
            shadow_q      <= shadow_d;
            shadow_vld_q  <= shadow_vld_d;
            gap_q         <= gap_d;
            busy_q        <= busy_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            tx_data_q     <= tx_data_d;
            drop_q        <= drop_d;
        end
    end

    tx_byte_handshake u_handshake (
        .i_clock     (i_clock),
        .i_nReset    (i_nReset),
        .i_start     (capture),
        .i_last      (last_byte),
        .i_txReady   (i_txReady),
        .o_txValid   (tx_valid),
        .o_byte_done (byte_done)
    );

    assign o_txData    = tx_data_q;
    assign o_txValid   = tx_valid;
    assign o_busy      = busy_q;
    assign o_dropCount = drop_q;

endmodule
